activation_collector: RTL and testbench
=======================================

Name: activation_collector

Overview:
- Receive end of the fullInference output interface.
- Captures each 64-bit `activations` word qualified by `activation_ready` into a small result FIFO.
- Counts rows against a per-batch expected count.
- Streams the results to the host/readback side over a valid/ready handshake, tagging the final word of each batch and pulsing a completion strobe once the batch has fully drained.

Parameters:
- DATA_W, 64, width of one activation row (8 lanes x 8 bits).
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- ROWS, 8, maximum rows per batch; also the default when num_rows = 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse; starts a new batch, latches num_rows, flushes the FIFO.
- num_rows  in  $clog2(ROWS)+1  expected rows this batch; 0 means ROWS.
- activation_ready  in  1  `activations` word valid this cycle.
- activations  in  DATA_W  result row from fullInference.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  DATA_W  FIFO head word (show-ahead).
- out_last  out  1  head word is the final row of the batch.
- batch_done  out  1  one-cycle pulse when the last row is popped.
- overflow  out  1  sticky: a push was dropped; cleared by arm or rst.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs are 0 on the cycle after rst is sampled high. The FIFO is empty, pointers and counters are 0, state is IDLE, and the latched row target is ROWS.
- States: IDLE, COLLECT, DRAIN.
- IDLE -> COLLECT on arm.
- COLLECT -> DRAIN when the accepted-row count reaches the target.
- DRAIN -> IDLE on the cycle the out_last word is popped; batch_done pulses on that same pop cycle (registered, visible the next cycle).
- arm in any state:
  - forces COLLECT;
  - empties the FIFO and zeroes the push/pop counters;
  - clears overflow;
  - latches the target: ROWS if num_rows = 0, otherwise min(num_rows, ROWS).
  - arm has priority over a same-cycle push or pop: both are discarded and overflow is not set.
- Push rule: accepted iff state = COLLECT, rows pushed < target, and (not full OR a pop occurs this cycle).
- Drop rule: any activation_ready not accepted sets overflow. This covers IDLE, DRAIN, rows beyond the target, and full without a pop.
- Pop rule: pop = out_valid & out_ready; out_valid = not empty.
- out_data is the memory at the read pointer (show-ahead). Latency from an accepted push to out_valid is 1 cycle.
- Simultaneous push and pop:
  - when full: occupancy unchanged, both succeed;
  - when empty: the pushed word appears the next cycle, and the pop is impossible because out_valid = 0.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit:
  - full = addresses equal and wrap bits differ;
  - empty = pointers equal.
- out_last = out_valid & (pop count = target - 1).
- out_data is held stable while out_valid & !out_ready.
- Reset mid-batch discards all contents; no batch_done is generated.
- The block never modifies data; lanes are passed through bit-exact.

Decomposition:
- Shared package (systolic_pkg):
  - DATA_W and ROWS constants;
  - collector_state_t enum {IDLE, COLLECT, DRAIN};
  - row-count typedef of width $clog2(ROWS)+1.
- One sub-module: sync_fifo (parameterised by DATA_W and DEPTH; push, pop, flush, full, empty, head data).
- The top level holds the FSM, row counters, overflow flag and out_last/batch_done logic.

Test Plan:
- Reset, then arm with num_rows = 3. Push 64'h0102030405060708, 64'h050a050a050a050a and 64'h0408040804080408 on consecutive cycles with out_ready = 1 -> three words out in order, each 1 cycle after its push. out_last is high only on the third; batch_done pulses once; state returns to IDLE.
- Arm with num_rows = 0 and out_ready = 0, then push 8 words -> all accepted and full. A 9th push sets overflow. Raising out_ready drains all 8 in order, with out_last on the 8th.
- With DEPTH = 8, num_rows = 8 and out_ready toggling every cycle, pushes continue every cycle -> no overflow, order preserved, and pointers wrap correctly.
- activation_ready while IDLE with data 64'hBAD1DEADBEEFBAD1 -> not captured, overflow = 1. The next arm clears overflow.
- Arm during a DRAIN that holds 2 pending words, with a same-cycle push -> FIFO empty next cycle, pushed word discarded, no batch_done, overflow = 0.
- Assert rst mid-COLLECT after 2 of 4 rows -> next cycle out_valid = 0, busy = 0, overflow = 0, and no batch_done.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the activation collector.
//   DEFAULT_DATA_W    : width of one activation row (8 lanes x 8 bits)
//   DEFAULT_ROWS      : maximum rows per batch
//   collector_state_t : collector FSM states
//   row_count_t       : row counter / row target type for the default ROWS
package systolic_pkg;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_ROWS   = 8;
    localparam int ROW_CNT_W      = $clog2(DEFAULT_ROWS) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } collector_state_t;

    typedef logic [ROW_CNT_W-1:0] row_count_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst   : clock and synchronous active-high reset
//   flush      : empties the FIFO (pointers back to 0)
//   push, push_data : write one word (caller guarantees not full unless popping)
//   pop        : discard the head word (caller guarantees not empty)
//   full, empty: occupancy flags
//   head       : word at the read pointer, 0 while empty
module sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Extra MSB on each pointer is the wrap bit that separates full from empty.
    logic [ADDR_W:0]   wr_ptr_reg;
    logic [ADDR_W:0]   rd_ptr_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (ADDR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (ADDR_W+1)'(1);
            end
        end
    end

    // Storage is not reset so it can map onto RAM; a simultaneous push/pop
    // when full writes the slot being vacated, whose old value was already
    // presented on head during this cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= push_data;
        end
    end

    always_comb begin
        empty = (wr_ptr_reg == rd_ptr_reg);
        full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
        // Masked while empty so an uninitialised slot never reaches the port.
        head  = empty ? '0 : mem[rd_ptr_reg[ADDR_W-1:0]];
    end

endmodule

// File: rtl/activation_collector.sv
// Collects activation rows from the inference datapath into a small FIFO and
// streams them to the readback side.
//   clk, rst          : clock and synchronous active-high reset
//   arm, num_rows     : start a batch of num_rows rows (0 = ROWS), flush FIFO
//   activation_ready, activations : incoming row strobe and data
//   out_valid, out_ready, out_data, out_last : show-ahead output stream
//   batch_done        : one-cycle pulse after the last row of a batch is popped
//   overflow          : sticky, a row was dropped since the last arm/reset
//   busy              : FSM is not IDLE
module activation_collector
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 8,
    parameter int ROWS   = DEFAULT_ROWS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic [$clog2(ROWS):0]      num_rows,
    input  logic                       activation_ready,
    input  logic [DATA_W-1:0]          activations,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    output logic                       batch_done,
    output logic                       overflow,
    output logic                       busy
);

    localparam int RC_W = $clog2(ROWS) + 1;

    collector_state_t state_reg, state_next;
    logic [RC_W-1:0]  target_reg;
    logic [RC_W-1:0]  push_cnt_reg;
    logic [RC_W-1:0]  pop_cnt_reg;
    logic             overflow_reg;
    logic             batch_done_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    logic             push;
    logic             pop;
    logic             drop;
    logic             is_last;
    logic [RC_W-1:0]  target_arm;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (arm),
        .push      (push),
        .push_data (activations),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Handshake decode and next-state logic. arm suppresses push and pop so a
    // flush never races with a same-cycle transfer.
    always_comb begin
        state_next = state_reg;
        pop        = !fifo_empty && out_ready && !arm;
        push       = !arm && activation_ready && (state_reg == COLLECT) &&
                     (push_cnt_reg < target_reg) && (!fifo_full || pop);
        drop       = !arm && activation_ready && !push;
        is_last    = !fifo_empty && (pop_cnt_reg == target_reg - RC_W'(1));
        target_arm = ((num_rows == '0) || (num_rows > RC_W'(ROWS))) ?
                     RC_W'(ROWS) : num_rows;

        if (arm) begin
            state_next = COLLECT;
        end else begin
            case (state_reg)
                IDLE:    state_next = IDLE;
                COLLECT: if (push && (push_cnt_reg + RC_W'(1) == target_reg))
                             state_next = DRAIN;
                DRAIN:   if (pop && is_last)
                             state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_reg     <= RC_W'(ROWS);
            push_cnt_reg   <= '0;
            pop_cnt_reg    <= '0;
            overflow_reg   <= 1'b0;
            batch_done_reg <= 1'b0;
        end else if (arm) begin
            target_reg     <= target_arm;
            push_cnt_reg   <= '0;
            pop_cnt_reg    <= '0;
            overflow_reg   <= 1'b0;
            batch_done_reg <= 1'b0;
        end else begin
            if (push) begin
                push_cnt_reg <= push_cnt_reg + RC_W'(1);
            end
            if (pop) begin
                pop_cnt_reg <= pop_cnt_reg + RC_W'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            batch_done_reg <= pop && is_last;
        end
    end

    always_comb begin
        out_valid  = !fifo_empty;
        out_data   = fifo_head;
        out_last   = is_last;
        batch_done = batch_done_reg;
        overflow   = overflow_reg;
        busy       = (state_reg != IDLE);
    end

endmodule

// File: tb/tb_activation_collector.sv
module tb_activation_collector;
    import systolic_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int ROWS  = 8;
    localparam int RC_W  = $clog2(ROWS) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            arm;
    logic [RC_W-1:0] num_rows;
    logic            activation_ready;
    logic [DW-1:0]   activations;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            batch_done;
    logic            overflow;
    logic            busy;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    activation_collector #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ROWS   (ROWS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .arm              (arm),
        .num_rows         (num_rows),
        .activation_ready (activation_ready),
        .activations      (activations),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .batch_done       (batch_done),
        .overflow         (overflow),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; num_rows = '0; activation_ready = 1'b0;
        activations = '0; out_ready = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if ({out_last, batch_done, overflow, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got last/done/ovf/busy=%b expected 0000", {out_last, batch_done, overflow, busy}); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
        $display("reset: done");
    endtask

    task automatic test_basic();
        logic [DW-1:0] words [3];
        exp_t e;
        words[0] = 64'h0102030405060708;
        words[1] = 64'h050a050a050a050a;
        words[2] = 64'h0408040804080408;
        arm = 1'b1; num_rows = RC_W'(3);
        tick();
        arm = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            activation_ready = 1'b1; activations = words[i];
            e.data = words[i]; e.last = (i == 2);
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                n_fail++;
                $display("FAIL basic_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", i, out_valid, out_data, out_last, e.data, e.last);
            end
            $display("basic: row %0d data=%h last=%b", i, out_data, out_last);
        end
        activation_ready = 1'b0;
        tick();
        out_ready = 1'b0;
        n_checks++; if (batch_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b v=%b expected 1 0 0", batch_done, busy, out_valid); end
        tick();
        n_checks++; if (batch_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", batch_done); end
    endtask

    task automatic test_full_overflow();
        exp_t e;
        arm = 1'b1; num_rows = '0; out_ready = 1'b0;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            activation_ready = 1'b1; activations = {32'(i + 1), 32'hA5A5_0000 | 32'(i)};
            e.data = activations; e.last = (i == 7);
            exp_q.push_back(e);
            tick();
        end
        n_checks++; if (overflow !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL full_before_ninth: got ovf=%b v=%b expected 0 1", overflow, out_valid); end
        activations = 64'hFFFF_0009_FFFF_0009;
        tick();
        activation_ready = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ninth_overflow: got %b expected 1", overflow); end
        n_checks++; if (out_data !== exp_q[0].data || out_last !== 1'b0) begin n_fail++; $display("FAIL full_hold: got d=%h l=%b expected d=%h l=0", out_data, out_last, exp_q[0].data); end
        $display("full: 8 queued, overflow=%b", overflow);
        out_ready = 1'b1;
        for (int c = 0; c < 32 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL full_drain: got d=%h l=%b expected d=%h l=%b", out_data, out_last, e.data, e.last);
                end
                $display("full: drained data=%h last=%b", out_data, out_last);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain_timeout: %0d words left expected 0", exp_q.size()); exp_q.delete(); end
        n_checks++; if (batch_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL full_done: got done=%b busy=%b expected 1 0", batch_done, busy); end
        tick();
    endtask

    task automatic test_toggle();
        exp_t e;
        int pushed = 0;
        int done_seen = 0;
        arm = 1'b1; num_rows = RC_W'(8);
        tick();
        arm = 1'b0;
        for (int c = 0; c < 64; c++) begin
            out_ready = (c % 2) == 1;
            if (pushed < 8) begin
                activation_ready = 1'b1; activations = {$urandom(), $urandom()};
                e.data = activations; e.last = (pushed == 7);
                exp_q.push_back(e);
                pushed++;
            end else begin
                activation_ready = 1'b0;
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL toggle_word: got d=%h l=%b expected d=%h l=%b", out_data, out_last, e.data, e.last);
                end
                $display("toggle: popped data=%h last=%b", out_data, out_last);
            end
            tick();
            if (batch_done) done_seen++;
            if (pushed == 8 && exp_q.size() == 0) break;
        end
        activation_ready = 1'b0; out_ready = 1'b0;
        tick();
        if (batch_done) done_seen++;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL toggle_timeout: %0d words left expected 0", exp_q.size()); exp_q.delete(); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL toggle_overflow: got %b expected 0", overflow); end
        n_checks++; if (done_seen != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL toggle_done: got %0d pulses busy=%b expected 1 0", done_seen, busy); end
    endtask

    task automatic test_idle_drop();
        activation_ready = 1'b1; activations = 64'hBAD1DEADBEEFBAD1;
        tick();
        activation_ready = 1'b0;
        n_checks++; if (overflow !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_drop: got ovf=%b v=%b expected 1 0", overflow, out_valid); end
        $display("idle: dropped word, overflow=%b", overflow);
        arm = 1'b1; num_rows = RC_W'(2);
        tick();
        arm = 1'b0;
        n_checks++; if (overflow !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_arm_clear: got ovf=%b v=%b expected 0 0", overflow, out_valid); end
    endtask

    task automatic test_arm_in_drain();
        int done_seen = 0;
        arm = 1'b1; num_rows = RC_W'(2); out_ready = 1'b0;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 2; i++) begin
            activation_ready = 1'b1; activations = 64'h1111_0000_0000_0000 | 64'(i);
            tick();
        end
        activation_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL drain_pending: got v=%b busy=%b expected 1 1", out_valid, busy); end
        arm = 1'b1; num_rows = RC_W'(2); activation_ready = 1'b1;
        activations = 64'hDEAD_0000_0000_0003; out_ready = 1'b1;
        tick();
        arm = 1'b0; activation_ready = 1'b0; out_ready = 1'b0;
        if (batch_done) done_seen++;
        n_checks++; if (out_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL drain_rearm: got v=%b ovf=%b busy=%b expected 0 0 1", out_valid, overflow, busy); end
        tick();
        if (batch_done) done_seen++;
        n_checks++; if (done_seen != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_rearm_done: got %0d pulses v=%b expected 0 0", done_seen, out_valid); end
        $display("drain: rearmed, fifo empty=%b", !out_valid);
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        arm = 1'b1; num_rows = RC_W'(4); out_ready = 1'b0;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 2; i++) begin
            activation_ready = 1'b1; activations = 64'h2222_0000_0000_0000 | 64'(i);
            tick();
        end
        activation_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_before: got v=%b busy=%b expected 1 1", out_valid, busy); end
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        if (batch_done) done_seen++;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL midrst_after: got v=%b busy=%b ovf=%b d=%h expected 0 0 0 0", out_valid, busy, overflow, out_data); end
        tick();
        if (batch_done) done_seen++;
        n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL midrst_done: got %0d pulses expected 0", done_seen); end
        $display("midrst: state cleared");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_toggle();
        test_idle_drop();
        test_arm_in_drain();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
